// File: rtl/regwrite_arb_if.sv
// -----------------------------------------------------------------------------
// regwrite_arb_if
// Bundles the producer handshakes and the register-file write port of the
// writeback arbiter.
//
// Handshake semantics (both producer channels): a transfer completes on a
// rising clock edge where valid and ready are both high. The producer holds
// its address/data stable while valid is high. Ready never depends on the
// same-cycle valid, so a producer may raise valid in response to ready.
//
// Signals:
//   alu_valid/alu_ready/alu_waddr/alu_wdata : single-cycle ALU result channel
//   ld_valid/ld_ready/ld_waddr/ld_wdata     : load-return channel
//   we/waddr/wdata                          : registered register-file write port
//   pend_mask                               : registers with a queued load write
//   waw_err                                 : sticky ALU-over-pending-load flag
// Modports: slave = arbiter view, master = producer/consumer view.
// -----------------------------------------------------------------------------
interface regwrite_arb_if #(
  parameter int RADDRWIDTH = 3,
  parameter int REGWIDTH   = 16
);
  logic                       alu_valid;
  logic                       alu_ready;
  logic [RADDRWIDTH-1:0]      alu_waddr;
  logic [REGWIDTH-1:0]        alu_wdata;
  logic                       ld_valid;
  logic                       ld_ready;
  logic [RADDRWIDTH-1:0]      ld_waddr;
  logic [REGWIDTH-1:0]        ld_wdata;
  logic                       we;
  logic [RADDRWIDTH-1:0]      waddr;
  logic [REGWIDTH-1:0]        wdata;
  logic [2**RADDRWIDTH-1:0]   pend_mask;
  logic                       waw_err;

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, ld_valid, ld_waddr, ld_wdata,
    output alu_ready, ld_ready, we, waddr, wdata, pend_mask, waw_err
  );

  modport master (
    output alu_valid, alu_waddr, alu_wdata, ld_valid, ld_waddr, ld_wdata,
    input  alu_ready, ld_ready, we, waddr, wdata, pend_mask, waw_err
  );
endinterface

// File: rtl/regwrite_arb.sv
// -----------------------------------------------------------------------------
// regwrite_arb
// Drives the register file's single write port from two producers: the ALU
// result path (priority) and the load-return path (buffered in a small FIFO,
// drained on idle ALU cycles). A starvation counter forces a load drain after
// STARVE_LIMIT consecutive ALU grants while loads wait. pend_mask exposes the
// registers that still have a load write queued or in the output stage.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : regwrite_arb_if.slave (producer channels + write port + status)
// -----------------------------------------------------------------------------
module regwrite_arb #(
  parameter int RADDRWIDTH   = 3,
  parameter int REGWIDTH     = 16,
  parameter int LQDEPTH      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  regwrite_arb_if.slave      bus
);

  localparam int AW = (LQDEPTH > 1) ? $clog2(LQDEPTH) : 1;
  localparam int PW = AW + 1;                       // extra bit tells full from empty
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int NR = 2 ** RADDRWIDTH;

  // Load FIFO storage and pointers
  logic [RADDRWIDTH-1:0] lq_addr [LQDEPTH];
  logic [REGWIDTH-1:0]   lq_data [LQDEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         lq_count;
  logic                  lq_empty;
  logic                  lq_full;

  logic [CW-1:0]         starve_cnt;

  // Output stage
  logic                  we_q;
  logic                  from_ld_q;                 // output write came from the FIFO
  logic [RADDRWIDTH-1:0] waddr_q;
  logic [REGWIDTH-1:0]   wdata_q;
  logic                  waw_q;
  logic [NR-1:0]         pend;

  logic                  alu_sel;
  logic                  ld_push;
  logic                  pop;
  logic [RADDRWIDTH-1:0] head_addr;
  logic [REGWIDTH-1:0]   head_data;

  assign lq_empty  = (wr_ptr == rd_ptr);
  assign lq_full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign lq_count  = wr_ptr - rd_ptr;
  assign head_addr = lq_addr[rd_ptr[AW-1:0]];
  assign head_data = lq_data[rd_ptr[AW-1:0]];

  // Both readies come from registered state only, never from same-cycle valids.
  assign bus.ld_ready  = !lq_full;
  assign bus.alu_ready = (starve_cnt != CW'(STARVE_LIMIT));

  assign alu_sel = bus.alu_valid && bus.alu_ready;
  // Loads to r0 complete the handshake but are dropped before the FIFO.
  assign ld_push = bus.ld_valid && !lq_full && (bus.ld_waddr != '0);
  // Pop decision looks only at entries already stored, so no same-cycle bypass.
  assign pop     = !alu_sel && !lq_empty;

  // Pending-load mask: every occupied FIFO slot plus a load in the output stage.
  always_comb begin
    pend = '0;
    for (int k = 0; k < LQDEPTH; k++) begin
      if (PW'(k) < lq_count) begin
        pend[lq_addr[AW'(rd_ptr[AW-1:0] + AW'(k))]] = 1'b1;
      end
    end
    if (we_q && from_ld_q) begin
      pend[waddr_q] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.pend_mask = pend;
  assign bus.waw_err   = waw_q;

  // FIFO payload needs no reset: only slots inside [rd_ptr, wr_ptr) are read.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      lq_addr[wr_ptr[AW-1:0]] <= bus.ld_waddr;
      lq_data[wr_ptr[AW-1:0]] <= bus.ld_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      from_ld_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      waw_q      <= 1'b0;
    end else begin
      if (ld_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);

      // Counts ALU wins over a waiting load; at the limit alu_ready drops,
      // the head pops and the count restarts.
      if (pop || lq_empty) begin
        starve_cnt <= '0;
      end else if (alu_sel) begin
        starve_cnt <= starve_cnt + CW'(1);
      end

      // FIFO entries never hold r0, so a pop always writes.
      we_q      <= (alu_sel && (bus.alu_waddr != '0)) || pop;
      from_ld_q <= pop;
      if (alu_sel) begin
        waddr_q <= bus.alu_waddr;
        wdata_q <= bus.alu_wdata;
      end else if (pop) begin
        waddr_q <= head_addr;
        wdata_q <= head_data;
      end

      if (alu_sel && (bus.alu_waddr != '0) && pend[bus.alu_waddr]) begin
        waw_q <= 1'b1;
      end
    end
  end

endmodule
